tape_ctrl: RTL and testbench

Sequencing and memory-sharing controller for the Aquarius cassette emulation. It owns the single tape-image RAM port and gives it either to the OSD loader, which downloads a tape image, or to the tape player, which streams bytes out as mark/space audio. It also generates the player's bit-cell clock strobe and sequences play, stop and rewind commands into the player's `ctrl` and reset inputs. It sits between the loader, the tape RAM and the tape player.

---
 rtl/tape_ctrl_if.sv | 21 ++
 rtl/tape_ctrl.sv | 177 +++++++++++++++++
 tb/tb_tape_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/tape_ctrl_if.sv
// Loader-side download bus and the shared tape-image RAM port.
// The master drives the loader strobes. The slave (tape_ctrl) drives the RAM port.
interface tape_ctrl_if;
    logic        dl_active;
    logic        dl_wr;
    logic [15:0] dl_addr;
    logic [7:0]  dl_data;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;

    modport master (
        output dl_active, dl_wr, dl_addr, dl_data,
        input  ram_addr, ram_din, ram_we
    );

    modport slave (
        input  dl_active, dl_wr, dl_addr, dl_data,
        output ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/tape_ctrl.sv
// Cassette emulation sequencer: arbitrates the tape RAM between loader and player,
// generates the bit-cell strobe and drives the player's ctrl/reset inputs.
module tape_ctrl #(
    parameter int CLK_DIV = 2400,
    parameter int TMO     = 8
) (
    input  logic         clk,
    input  logic         reset,
    tape_ctrl_if.slave   bus,
    input  logic         key_play,
    input  logic         key_stop,
    input  logic         key_rewind,
    input  logic         tape_req,
    input  logic [15:0]  tape_addr,
    output logic [15:0]  length,
    output logic [1:0]   ctrl,
    output logic         player_reset,
    output logic         tape_clk,
    output logic [2:0]   status
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int TMO_W = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        LOAD   = 3'd1,
        READY  = 3'd2,
        PLAY   = 3'd3,
        REWIND = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        length_q, length_d;
    logic [1:0]         ctrl_q, ctrl_d;
    logic               player_reset_q, player_reset_d;
    logic               tape_clk_q, tape_clk_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               seen_req_q, seen_req_d;
    logic               rew_cnt_q, rew_cnt_d;
    logic               tape_req_q;

    // Highest written address + 1, saturating so a write at 0xFFFF reports 0xFFFF.
    function automatic logic [15:0] grow_length(input logic [15:0] cur, input logic [15:0] addr);
        logic [16:0] inc;
        logic [15:0] sat;
        inc = {1'b0, addr} + 17'd1;
        sat = inc[16] ? 16'hFFFF : inc[15:0];
        return (sat > cur) ? sat : cur;
    endfunction

    logic tape_req_fall;
    logic play_timeout;
    assign tape_req_fall = tape_req_q && !tape_req;
    assign play_timeout  = !seen_req_q && !tape_req && (tmo_cnt_q == TMO_W'(TMO - 1));

    always_comb begin
        state_d        = state_q;
        length_d       = length_q;
        ctrl_d         = 2'd0;
        player_reset_d = 1'b0;
        rew_cnt_d      = 1'b0;
        tmo_cnt_d      = tmo_cnt_q;
        seen_req_d     = seen_req_q;
        if (div_cnt_q == DIV_W'(CLK_DIV - 1)) begin
            div_cnt_d  = '0;
            tape_clk_d = 1'b1;
        end else begin
            div_cnt_d  = div_cnt_q + 1'b1;
            tape_clk_d = 1'b0;
        end

        if (bus.dl_active) begin
            if (state_q != LOAD) begin
                state_d        = LOAD;
                length_d       = '0;
                // Aborting an active player keeps it in reset for the whole download.
                player_reset_d = (state_q == PLAY) || (state_q == REWIND);
            end else begin
                player_reset_d = player_reset_q;
                if (bus.dl_wr)
                    length_d = grow_length(length_q, bus.dl_addr);
            end
        end else begin
            case (state_q)
                LOAD: begin
                    if (length_q == 16'd0) begin
                        state_d = EMPTY;
                    end else begin
                        state_d        = REWIND;
                        player_reset_d = 1'b1;
                    end
                end
                READY: begin
                    if (key_stop) begin
                        state_d = READY;
                    end else if (key_rewind) begin
                        state_d        = REWIND;
                        player_reset_d = 1'b1;
                    end else if (key_play) begin
                        state_d    = PLAY;
                        ctrl_d     = 2'd1;
                        tmo_cnt_d  = '0;
                        seen_req_d = 1'b0;
                        div_cnt_d  = '0;
                        tape_clk_d = 1'b0;
                    end
                end
                PLAY: begin
                    if (key_stop || key_rewind || tape_req_fall || play_timeout) begin
                        state_d        = REWIND;
                        player_reset_d = 1'b1;
                    end else begin
                        ctrl_d = (ctrl_q == 2'd1 && !tape_req) ? 2'd1 : 2'd0;
                        if (tape_req)
                            seen_req_d = 1'b1;
                        if (!seen_req_q)
                            tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
                REWIND: begin
                    if (rew_cnt_q) begin
                        state_d = READY;
                    end else begin
                        rew_cnt_d      = 1'b1;
                        player_reset_d = 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= EMPTY;
            length_q       <= '0;
            ctrl_q         <= 2'd0;
            player_reset_q <= 1'b0;
            tape_clk_q     <= 1'b0;
            div_cnt_q      <= '0;
            tmo_cnt_q      <= '0;
            seen_req_q     <= 1'b0;
            rew_cnt_q      <= 1'b0;
            tape_req_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            length_q       <= length_d;
            ctrl_q         <= ctrl_d;
            player_reset_q <= player_reset_d;
            tape_clk_q     <= tape_clk_d;
            div_cnt_q      <= div_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            seen_req_q     <= seen_req_d;
            rew_cnt_q      <= rew_cnt_d;
            tape_req_q     <= tape_req;
        end
    end

    // RAM port follows the registered state; writes only while the download is live.
    always_comb begin
        bus.ram_addr = tape_addr;
        bus.ram_din  = 8'd0;
        bus.ram_we   = 1'b0;
        if (state_q == LOAD) begin
            bus.ram_addr = bus.dl_addr;
            bus.ram_din  = bus.dl_data;
            bus.ram_we   = bus.dl_wr && bus.dl_active;
        end
    end

    assign length       = length_q;
    assign ctrl         = ctrl_q;
    assign player_reset = player_reset_q;
    assign tape_clk     = tape_clk_q;
    assign status       = state_q;
endmodule

// File: tb/tb_tape_ctrl.sv
// Directed bench for tape_ctrl: load, play, divider, abort, timeout and saturation.
module tb_tape_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        key_play, key_stop, key_rewind;
    logic        tape_req;
    logic [15:0] tape_addr;
    logic [15:0] length;
    logic [1:0]  ctrl;
    logic        player_reset;
    logic        tape_clk;
    logic [2:0]  status;
    int          checks = 0;
    int          failures = 0;
    int          ctrl_hi;

    tape_ctrl_if bus ();

    tape_ctrl #(.CLK_DIV(2400), .TMO(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .key_play     (key_play),
        .key_stop     (key_stop),
        .key_rewind   (key_rewind),
        .tape_req     (tape_req),
        .tape_addr    (tape_addr),
        .length       (length),
        .ctrl         (ctrl),
        .player_reset (player_reset),
        .tape_clk     (tape_clk),
        .status       (status)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        key_play = 0; key_stop = 0; key_rewind = 0;
        tape_req = 0; tape_addr = 16'h1234;
        bus.dl_active = 0; bus.dl_wr = 0; bus.dl_addr = '0; bus.dl_data = '0;
        tick(); tick();
        reset = 1'b0;
        check_eq("rst_status", 32'(status), 32'd0);
        check_eq("rst_length", 32'(length), 32'd0);
        check_eq("rst_ctrl", 32'(ctrl), 32'd0);
        check_eq("rst_preset", 32'(player_reset), 32'd0);
        check_eq("rst_tclk", 32'(tape_clk), 32'd0);

        key_play = 1; tick(); key_play = 0;
        check_eq("empty_play", 32'(status), 32'd0);

        // Download 100 bytes
        bus.dl_active = 1; tick();
        check_eq("load_status", 32'(status), 32'd1);
        check_eq("load_preset", 32'(player_reset), 32'd0);
        for (int i = 0; i < 100; i++) begin
            bus.dl_wr = 1; bus.dl_addr = 16'(i); bus.dl_data = 8'(i);
            #1;
            check_eq("load_we", 32'(bus.ram_we), 32'd1);
            check_eq("load_addr", 32'(bus.ram_addr), 32'(i));
            tick();
        end
        bus.dl_wr = 0;
        check_eq("load_len", 32'(length), 32'd100);
        bus.dl_active = 0; tick();
        check_eq("rew1_status", 32'(status), 32'd4);
        check_eq("rew1_preset", 32'(player_reset), 32'd1);
        tick();
        check_eq("rew2_status", 32'(status), 32'd4);
        check_eq("rew2_preset", 32'(player_reset), 32'd1);
        tick();
        check_eq("ready_status", 32'(status), 32'd2);
        check_eq("ready_preset", 32'(player_reset), 32'd0);
        check_eq("ready_we", 32'(bus.ram_we), 32'd0);
        check_eq("ready_addr", 32'(bus.ram_addr), 32'h1234);

        // Play to end of image
        ctrl_hi = 0;
        key_play = 1; tick(); key_play = 0;
        check_eq("play_status", 32'(status), 32'd3);
        check_eq("play_ctrl", 32'(ctrl), 32'd1);
        if (ctrl == 2'd1) ctrl_hi++;
        tick();
        if (ctrl == 2'd1) ctrl_hi++;
        tape_req = 1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (ctrl == 2'd1) ctrl_hi++;
        end
        check_eq("play_ctrl_cycles", 32'(ctrl_hi), 32'd2);
        check_eq("play_hold_status", 32'(status), 32'd3);
        tape_req = 0; tick();
        check_eq("eoi_status", 32'(status), 32'd4);
        check_eq("eoi_preset", 32'(player_reset), 32'd1);
        tick(); tick();
        check_eq("eoi_ready", 32'(status), 32'd2);

        // Divider: strobes at T+2400 and T+4800 after PLAY entry
        key_play = 1; tick(); key_play = 0;
        check_eq("div_entry_tclk", 32'(tape_clk), 32'd0);
        tape_req = 1;
        for (int k = 1; k <= 4810; k++) begin
            tick();
            check_eq("div_tclk", 32'(tape_clk), (k == 2400 || k == 4800) ? 32'd1 : 32'd0);
        end
        check_eq("div_status", 32'(status), 32'd3);
        tape_req = 0; tick(); tick(); tick();
        check_eq("div_ready", 32'(status), 32'd2);

        // Timeout with no tape_req
        key_play = 1; tick(); key_play = 0;
        check_eq("tmo_status0", 32'(status), 32'd3);
        for (int k = 1; k < 8; k++) begin
            tick();
            check_eq("tmo_wait", 32'(status), 32'd3);
        end
        tick();
        check_eq("tmo_rewind", 32'(status), 32'd4);
        check_eq("tmo_ctrl", 32'(ctrl), 32'd0);
        tick(); tick();
        check_eq("tmo_ready", 32'(status), 32'd2);

        // READY: key_stop ignored, key_rewind rewinds
        key_stop = 1; tick(); key_stop = 0;
        check_eq("ready_stop", 32'(status), 32'd2);
        key_rewind = 1; tick(); key_rewind = 0;
        check_eq("ready_rew", 32'(status), 32'd4);
        tick(); tick();
        check_eq("ready_rew_done", 32'(status), 32'd2);

        // Abort PLAY with simultaneous key_stop and dl_active
        key_play = 1; tick(); key_play = 0;
        tape_req = 1; tick(); tick();
        check_eq("abort_pre_ctrl", 32'(ctrl), 32'd0);
        key_stop = 1; bus.dl_active = 1; tick(); key_stop = 0;
        check_eq("abort_status", 32'(status), 32'd1);
        check_eq("abort_ctrl", 32'(ctrl), 32'd0);
        check_eq("abort_preset", 32'(player_reset), 32'd1);
        check_eq("abort_len", 32'(length), 32'd0);
        tape_req = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("abort_hold_preset", 32'(player_reset), 32'd1);
            check_eq("abort_hold_status", 32'(status), 32'd1);
        end
        bus.dl_wr = 1; bus.dl_addr = 16'hFFFF; bus.dl_data = 8'hAA;
        #1;
        check_eq("sat_we", 32'(bus.ram_we), 32'd1);
        check_eq("sat_din", 32'(bus.ram_din), 32'hAA);
        tick(); bus.dl_wr = 0;
        check_eq("sat_len", 32'(length), 32'hFFFF);
        check_eq("sat_preset", 32'(player_reset), 32'd1);
        bus.dl_active = 0; tick();
        check_eq("abort_rew", 32'(status), 32'd4);
        tick(); tick();
        check_eq("abort_ready", 32'(status), 32'd2);
        check_eq("abort_ready_preset", 32'(player_reset), 32'd0);

        // Stray write outside a download
        bus.dl_wr = 1; bus.dl_addr = 16'h0200; bus.dl_data = 8'h55;
        #1;
        check_eq("stray_we", 32'(bus.ram_we), 32'd0);
        check_eq("stray_din", 32'(bus.ram_din), 32'd0);
        tick(); bus.dl_wr = 0;
        check_eq("stray_len", 32'(length), 32'hFFFF);

        // Empty download returns to EMPTY
        bus.dl_active = 1; tick();
        check_eq("empty_dl_status", 32'(status), 32'd1);
        check_eq("empty_dl_len", 32'(length), 32'd0);
        check_eq("empty_dl_preset", 32'(player_reset), 32'd0);
        bus.dl_active = 0; tick();
        check_eq("empty_dl_end", 32'(status), 32'd0);
        key_rewind = 1; tick(); key_rewind = 0;
        check_eq("empty_rew", 32'(status), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
